// File: rtl/signed_accum_seq_pkg.sv
// Shared types and constants for the signed accumulator and its saturating adder.
package signed_accum_seq_pkg;

  localparam int ACC_W = 32;

  // Saturation limits for the default accumulator width.
  localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/signed_sat_add.sv
// Combinational two's-complement adder with signed overflow detection and saturation.
module signed_sat_add
  import signed_accum_seq_pkg::*;
#(
  parameter int WIDTH = ACC_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] raw;

  assign raw = a + b;

  // Overflow only when both operands share a sign and the result's sign differs.
  assign ovf = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);

  assign sum = ovf ? (a[WIDTH-1] ? SAT_MIN : SAT_MAX) : raw;

endmodule

// File: rtl/signed_accum_seq.sv
// Job-based saturating signed accumulator with valid/ready input and output handshakes.
module signed_accum_seq
  import signed_accum_seq_pkg::*;
#(
  parameter int WIDTH = ACC_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic             ovf_reg, ovf_next;
  logic [CNT_W-1:0] remaining_reg, remaining_next;

  logic [WIDTH-1:0] add_sum;
  logic             add_ovf;

  signed_sat_add #(
    .WIDTH(WIDTH)
  ) u_sat_add (
    .a  (acc_reg),
    .b  (in_data),
    .sum(add_sum),
    .ovf(add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      acc_reg       <= '0;
      ovf_reg       <= 1'b0;
      remaining_reg <= '0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      ovf_reg       <= ovf_next;
      remaining_reg <= remaining_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    ovf_next       = ovf_reg;
    remaining_next = remaining_reg;
    in_ready       = 1'b0;
    out_valid      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          acc_next = '0;
          ovf_next = 1'b0;
          if (len != '0) begin
            remaining_next = len;
            state_next     = ST_ACCUM;
          end else begin
            state_next = ST_DONE;
          end
        end
      end

      ST_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_next       = add_sum;
          ovf_next       = ovf_reg | add_ovf;
          remaining_next = remaining_reg - 1'b1;
          // Counting down to one (not zero) lets a full-length job finish without wrap.
          if (remaining_reg == CNT_W'(1)) begin
            state_next = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign out_sum = acc_reg;
  assign out_ovf = ovf_reg;
  assign busy    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_signed_accum_seq.sv
// Directed-vector bench for signed_accum_seq: handshakes, saturation, stalls and reset abort.
module tb_signed_accum_seq;
  import signed_accum_seq_pkg::*;

  localparam int W = 32;
  localparam int C = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [C-1:0] len;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_ovf;
  logic         busy;

  int checks;
  int failures;

  signed_accum_seq #(
    .WIDTH(W),
    .CNT_W(C)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_ovf  (out_ovf),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic start_job(input logic [C-1:0] l);
    @(negedge clk);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_ovf, busy} !== 4'b0000 || out_sum !== '0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b vld=%b ovf=%b busy=%b sum=%h exp all 0",
               in_ready, out_valid, out_ovf, busy, out_sum);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got busy=%b rdy=%b exp 0 0", busy, in_ready);
    end
  endtask

  task automatic test_basic;
    start_job(8'd3);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_accum_ready got rdy=%b busy=%b exp 1 1", in_ready, busy);
    end
    feed(32'd5);
    feed(32'hFFFF_FFFE);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_early_valid got %b exp 0", out_valid);
    end
    feed(32'd10);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 32'd13 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_result got vld=%b sum=%h ovf=%b rdy=%b exp 1 0000000d 0 0",
               out_valid, out_sum, out_ovf, in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_one_cycle got vld=%b busy=%b exp 0 0", out_valid, busy);
    end
  endtask

  task automatic test_saturate;
    start_job(8'd2);
    feed(SMAX);
    feed(32'd1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== SMAX || out_ovf !== 1'b1) begin
      failures++;
      $display("FAIL sat_pos got vld=%b sum=%h ovf=%b exp 1 7fffffff 1", out_valid, out_sum, out_ovf);
    end
    @(negedge clk);
    start_job(8'd2);
    checks++;
    if (out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL sat_ovf_cleared got %b exp 0", out_ovf);
    end
    feed(SMIN);
    feed(32'hFFFF_FFFF);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== SMIN || out_ovf !== 1'b1) begin
      failures++;
      $display("FAIL sat_neg got vld=%b sum=%h ovf=%b exp 1 80000000 1", out_valid, out_sum, out_ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_sticky;
    start_job(8'd3);
    feed(SMAX);
    feed(32'd1);
    feed(32'hFFFF_FFFF);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 32'h7FFF_FFFE || out_ovf !== 1'b1) begin
      failures++;
      $display("FAIL sticky got vld=%b sum=%h ovf=%b exp 1 7ffffffe 1", out_valid, out_sum, out_ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_stall_backpressure;
    out_ready = 1'b0;
    start_job(8'd4);
    for (int v = 1; v <= 4; v++) begin
      feed(W'(v));
      if (v < 4) begin
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
          failures++;
          $display("FAIL stall_state got rdy=%b vld=%b exp 1 0", in_ready, out_valid);
        end
      end
    end
    in_valid = 1'b1;
    in_data  = 32'd100;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 32'd10 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d got vld=%b sum=%h ovf=%b rdy=%b exp 1 0000000a 0 0",
                 i, out_valid, out_sum, out_ovf, in_ready);
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL hold_release got vld=%b busy=%b exp 0 0", out_valid, busy);
    end
  endtask

  task automatic test_zero_len_and_ignored_start;
    start_job(8'd0);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== '0 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL zero_len got vld=%b sum=%h ovf=%b exp 1 00000000 0", out_valid, out_sum, out_ovf);
    end
    // Start coincides with the DONE->IDLE handshake and must be dropped.
    start = 1'b1;
    len   = 8'd1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL start_on_done got busy=%b vld=%b exp 0 0", busy, out_valid);
    end
    start_job(8'd2);
    feed(32'd3);
    start = 1'b1;
    len   = 8'd5;
    feed(32'd4);
    start = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 32'd7) begin
      failures++;
      $display("FAIL start_in_accum got vld=%b sum=%h exp 1 00000007", out_valid, out_sum);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_job;
    start_job(8'd5);
    feed(32'd1);
    feed(32'd2);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_ovf, busy} !== 4'b0000 || out_sum !== '0) begin
      failures++;
      $display("FAIL reset_abort got rdy=%b vld=%b ovf=%b busy=%b sum=%h exp all 0",
               in_ready, out_valid, out_ovf, busy, out_sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_job(8'd1);
    feed(32'hFFFF_FFF9);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 32'hFFFF_FFF9 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL after_reset_job got vld=%b sum=%h ovf=%b exp 1 fffffff9 0", out_valid, out_sum, out_ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_max_len;
    start_job(8'd255);
    for (int i = 0; i < 254; i++) begin
      feed(32'd1);
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL max_len_early got vld=%b busy=%b exp 0 1", out_valid, busy);
    end
    feed(32'd1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 32'd255) begin
      failures++;
      $display("FAIL max_len got vld=%b sum=%h exp 1 000000ff", out_valid, out_sum);
    end
    @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_saturate();
    test_sticky();
    test_stall_backpressure();
    test_zero_len_and_ignored_start();
    test_reset_mid_job();
    test_max_len();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/signed_accum_seq.md
Name: signed_accum_seq

Overview:
- Sequential accumulator that sits directly downstream of the 32-bit signed two's-complement adder stage.
- Consumes a stream of signed operands over a valid/ready handshake and sums each operand into a running accumulator using two's-complement addition.
- Detects signed overflow per step and saturates the accumulator; the overflow indication is sticky for the whole job.
- Presents the final sum, plus the sticky overflow flag, on an output valid/ready handshake after a programmed number of operands.

Parameters:
- WIDTH, 32, operand/accumulator width in bits (two's complement).
- CNT_W, 8, width of the operand-count field; maximum job length is 2^CNT_W - 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  one-cycle job start pulse; sampled only in IDLE.
- len  input  CNT_W  number of operands in the job; sampled together with start.
- in_valid  input  1  operand valid.
- in_ready  output  1  operand accepted when in_valid && in_ready.
- in_data  input  WIDTH  signed operand.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  WIDTH  saturated signed sum.
- out_ovf  output  1  sticky flag: at least one step overflowed and saturated.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; acc = 0; remaining count = 0; ovf = 0. All outputs are 0: in_ready, out_valid, out_sum, out_ovf, busy.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready = 0.
  - start && len != 0 -> ACCUM; acc <= 0, ovf <= 0, remaining <= len.
  - start && len == 0 -> DONE; acc <= 0, ovf <= 0.
- ACCUM:
  - in_ready = 1.
  - Each handshake: acc <= sat(acc + in_data); ovf <= ovf | step_ovf; remaining <= remaining - 1.
  - A handshake with remaining == 1 -> DONE.
  - Cycles with in_valid = 0 are stalls; no state changes.
- DONE:
  - out_valid = 1; out_sum = acc; out_ovf = ovf. All three are held stable until out_ready.
  - out_valid && out_ready -> IDLE. acc and ovf are retained, but out_valid drops.
- Latency: out_valid rises on the cycle after the last operand handshake. A zero-length job gives out_valid the cycle after start.
- Arithmetic:
  - raw = acc + in_data, computed modulo 2^WIDTH.
  - step_ovf = (acc[MSB] == in_data[MSB]) && (raw[MSB] != acc[MSB]).
  - On overflow, acc saturates: to 0x7FFF_FFFF (for WIDTH = 32) when both operands are non-negative, and to 0x8000_0000 when both are negative. Otherwise acc = raw.
  - Operands of mixed sign never overflow.
- Boundary conditions:
  - start outside IDLE is ignored, including start in the same cycle as the DONE->IDLE handshake. The new job needs start in IDLE.
  - in_valid in IDLE or DONE is not accepted, because in_ready = 0.
  - After a saturation, accumulation continues from the saturated value. Example: saturated max + (-1) = 0x7FFF_FFFE, and the sticky ovf stays 1.
  - len = 2^CNT_W - 1 must complete without wrapping the counter.
  - rst_n asserted mid-job aborts immediately to IDLE with all outputs 0. No partial result is emitted.

Decomposition:
- Shared package:
  - FSM state enum (IDLE, ACCUM, DONE).
  - WIDTH-derived constants SMAX and SMIN.
- One natural combinational sub-module, signed_sat_add: inputs a and b; outputs sum and ovf; implements the raw add, the overflow rule and the saturation above. It is reusable by the adder stage.
- The FSM, counter and registers stay in the top module.

Test Plan:
- len = 3, operands 5, -2, 10 with no stalls, out_ready = 1 -> out_sum = 13, out_ovf = 0, out_valid exactly one cycle, arriving the cycle after the 3rd handshake.
- len = 2, operands 0x7FFF_FFFF, 1 -> out_sum = 0x7FFF_FFFF, out_ovf = 1. Then len = 2, operands 0x8000_0000, -1 -> out_sum = 0x8000_0000, out_ovf = 1 (the flag was cleared at start and set again).
- len = 3, operands 0x7FFF_FFFF, 1, -1 -> out_sum = 0x7FFF_FFFE, out_ovf = 1 (sticky flag, accumulation continues from the saturated value).
- len = 4, operands 1, 2, 3, 4 with in_valid deasserted 2 cycles between each; out_ready held low 5 cycles -> out_sum = 10, held stable while out_ready is low; in_ready = 0 in DONE.
- len = 0 -> out_valid the cycle after start, out_sum = 0, out_ovf = 0. Pulse start during ACCUM and on the DONE->IDLE cycle -> both ignored.
- rst_n pulsed low after 2 of 5 operands -> immediate IDLE, all outputs 0. A fresh len = 1 job with operand -7 -> out_sum = 0xFFFF_FFF9.
